// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
package fetch_prefetch_unit_pkg;

    localparam int unsigned FetchXlen  = 32;
    localparam logic [31:0] NopInstr   = 32'h0000_0013;
    localparam logic [31:0] ResetPcDef = 32'h0000_0000;
    localparam int unsigned PcStep     = 4;

endpackage

// File: rtl/fetch_prefetch_unit_queue.sv
// Circular prefetch FIFO of {instr, pc}; flush wins over a same-cycle push.
module fetch_prefetch_unit_queue #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned QDEPTH = 4,
    parameter int unsigned CntW   = $clog2(QDEPTH) + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [CntW-1:0] o_count
);

    localparam int unsigned PtrW = $clog2(QDEPTH);

    logic [XLEN-1:0] instr_mem [QDEPTH];
    logic [XLEN-1:0] pc_mem    [QDEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            wr_en, rd_en, full;

    assign full = (count_q == CntW'(QDEPTH));

    always_comb begin
        wr_en    = i_push && !i_flush;
        rd_en    = i_pop && (count_q != '0) && !i_flush;
        wr_ptr_d = wr_ptr_q + PtrW'(wr_en);
        rd_ptr_d = rd_ptr_q + PtrW'(rd_en);
        count_d  = count_q + CntW'(wr_en) - CntW'(rd_en);
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: count_q qualifies every read.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            instr_mem[wr_ptr_q] <= i_instr;
            pc_mem[wr_ptr_q]    <= i_pc;
        end
    end

    assign o_instr = instr_mem[rd_ptr_q];
    assign o_pc    = pc_mem[rd_ptr_q];
    assign o_count = count_q;

    // The issue credit must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst)
        !(i_push && !i_flush && full && !i_pop));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the fetch PC, issues imem word requests and feeds decode from a
// prefetch queue, honouring stall, redirect and the single-step clock enable.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN      = FetchXlen,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(ResetPcDef),
    parameter int unsigned     QDEPTH    = 4,
    parameter int unsigned     MAX_OUTST = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clk_en,
    input  logic            i_stall_f,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_valid_f,
    output logic [XLEN-1:0] o_instr_f,
    output logic [XLEN-1:0] o_pc_f,
    output logic [XLEN-1:0] o_pc_plus4_f,
    output logic            o_misalign_f
);

    localparam int unsigned CntW = $clog2(QDEPTH) + 1;
    localparam int unsigned OutW = $clog2(MAX_OUTST + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [OutW-1:0] outst_q, outst_d;
    logic [OutW-1:0] drop_q, drop_d;
    logic            misalign_q, misalign_d;
    logic [CntW-1:0] q_count;
    logic [XLEN-1:0] head_instr, head_pc;
    logic            credit_ok, req, fire, push, pop, valid;

    // Credit covers both buffered entries and words still in flight.
    assign credit_ok = (32'(outst_q) + 32'(q_count) < QDEPTH) && (32'(outst_q) < MAX_OUTST);
    assign req       = i_clk_en && !i_redirect && credit_ok;
    assign fire      = req && i_imem_gnt;
    assign push      = i_imem_rvalid && (drop_q == '0) && !i_redirect;
    assign valid     = (q_count != '0);
    assign pop       = valid && i_clk_en && !i_stall_f && !i_redirect;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + OutW'(fire) - OutW'(i_imem_rvalid);
        drop_d     = drop_q;
        misalign_d = 1'b0;
        if (i_imem_rvalid && (drop_q != '0)) begin
            drop_d = drop_q - OutW'(1);
        end
        if (fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(PcStep);
        end
        if (i_redirect) begin
            fetch_pc_d = {i_redirect_pc[XLEN-1:2], 2'b00};
            // Everything still in flight after this cycle belongs to the old path.
            drop_d     = outst_d;
            misalign_d = |i_redirect_pc[1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_prefetch_unit_queue #(
        .XLEN   (XLEN),
        .QDEPTH (QDEPTH),
        .CntW   (CntW)
    ) u_queue (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (i_redirect),
        .i_instr (i_imem_rdata),
        .i_pc    (fetch_pc_q - XLEN'(PcStep) * XLEN'(outst_q)),
        .o_instr (head_instr),
        .o_pc    (head_pc),
        .o_count (q_count)
    );

    assign o_imem_req   = req;
    assign o_imem_addr  = fetch_pc_q;
    assign o_valid_f    = valid;
    assign o_instr_f    = valid ? head_instr : XLEN'(NopInstr);
    assign o_pc_f       = valid ? head_pc : '0;
    assign o_pc_plus4_f = o_pc_f + XLEN'(PcStep);
    assign o_misalign_f = misalign_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench: randomized imem timing and control against a program-order fetch model.
module tb_fetch_prefetch_unit;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en, stall_f, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        valid_f;
    logic [31:0] instr_f, pc_f, pc_plus4_f;
    logic        misalign_f;

    fetch_prefetch_unit dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_clk_en      (clk_en),
        .i_stall_f     (stall_f),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_valid_f     (valid_f),
        .o_instr_f     (instr_f),
        .o_pc_f        (pc_f),
        .o_pc_plus4_f  (pc_plus4_f),
        .o_misalign_f  (misalign_f)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    pend_t       pend[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned lat_min = 1, lat_max = 1;
    bit          rand_gnt = 1'b0;

    // Reference model: words in flight, words to discard, buffered words, program-order PCs.
    int          inflight, drop, occ, pops;
    logic [31:0] fetch_pc, next_pc;
    bit          exp_mis;

    logic [31:0] seen_pc, seen_instr;
    bit          seen_mis, saw_addr0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        inflight = 0;
        drop     = 0;
        occ      = 0;
        fetch_pc = 32'h0;
        next_pc  = 32'h0;
        exp_mis  = 1'b0;
        pend.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, valid_f}, 32'd0);
        check("rst_instr", instr_f, Nop);
        check("rst_pc", pc_f, 32'h0);
        check("rst_pc4", pc_plus4_f, 32'h4);
        check("rst_mis", {31'd0, misalign_f}, 32'd0);
    endtask

    task automatic step(input bit en, input bit stall, input bit redir, input logic [31:0] rpc);
        bit   fire_m, resp, pop_m;
        logic exp_req;
        @(negedge clk);
        cyc++;
        clk_en      = en;
        stall_f     = stall;
        redirect    = redir;
        redirect_pc = rpc;
        gnt         = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = memw(pend[0].addr);
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
        end
        #1;
        exp_req = en && !redir && (inflight + occ < 4) && (inflight < 2);
        check("req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check("addr", imem_addr, fetch_pc);
        check("valid", {31'd0, valid_f}, {31'd0, occ != 0});
        if (occ == 0) begin
            check("nop", instr_f, Nop);
        end else begin
            check("head_pc", pc_f, next_pc);
            check("head_instr", instr_f, memw(next_pc));
            check("head_pc4", pc_plus4_f, next_pc + 32'd4);
        end
        check("misalign", {31'd0, misalign_f}, {31'd0, exp_mis});
        seen_pc    = valid_f ? pc_f : 32'hDEAD_BEEF;
        seen_instr = instr_f;
        seen_mis   = misalign_f;
        if (imem_req && imem_addr == 32'h0) saw_addr0 = 1'b1;

        // The memory follows the real bus handshake; the model follows its own expectation.
        if (imem_req && gnt) pend.push_back('{addr: imem_addr, due: cyc + $urandom_range(lat_min, lat_max)});
        resp   = rvalid;
        if (resp) void'(pend.pop_front());
        fire_m = exp_req && gnt;
        pop_m  = (occ != 0) && en && !stall && !redir;
        inflight = inflight + int'(fire_m) - int'(resp);
        if (redir) begin
            drop     = inflight;
            occ      = 0;
            fetch_pc = {rpc[31:2], 2'b00};
            next_pc  = {rpc[31:2], 2'b00};
            exp_mis  = (rpc[1:0] != 2'b00);
        end else begin
            exp_mis = 1'b0;
            if (resp) begin
                if (drop > 0) drop--;
                else occ++;
            end
            if (pop_m) begin
                occ--;
                pops++;
                next_pc = next_pc + 32'd4;
            end
            if (fire_m) fetch_pc = fetch_pc + 32'd4;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; clk_en = 1'b0; stall_f = 1'b0; redirect = 1'b0; redirect_pc = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        pops = 0; saw_addr0 = 1'b0;
        model_reset();
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // 1-cycle memory, always granted, no stalls: addresses 0,4,8.. and in-order heads.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, '0);

        // Stall holds the head while fetching runs out of credit.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);

        // Redirect with two words in flight: both are discarded.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 12 && inflight < 2; i++) step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 20 && occ == 0; i++) step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        check("redir_head_pc", seen_pc, 32'h100);
        check("redir_head_instr", seen_instr, memw(32'h100));

        // Misaligned target: one-cycle pulse, fetch resumes word-aligned.
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b0, 1'b1, 32'h102);
        step(1'b1, 1'b0, 1'b0, '0);
        check("mis_pulse", {31'd0, seen_mis}, 32'd1);
        step(1'b1, 1'b0, 1'b0, '0);
        check("mis_clear", {31'd0, seen_mis}, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);

        // Single-step enable toggling with in-flight responses.
        lat_min = 1; lat_max = 3; rand_gnt = 1'b1;
        for (int i = 0; i < 40; i++) step(i[0], 1'b0, 1'b0, '0);

        // Fetch PC wraps past the top of the address space.
        lat_min = 1; lat_max = 1; rand_gnt = 1'b0;
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        saw_addr0 = 1'b0;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, '0);
        check("wrap_addr0", {31'd0, saw_addr0}, 32'd1);

        // Randomized control and memory timing.
        lat_min = 1; lat_max = 3; rand_gnt = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 24) == 0, $urandom);
        end

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
        @(negedge clk);
        clk_en = 1'b0; stall_f = 1'b0; redirect = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 1'b0, '0);

        check("progress", {31'd0, pops > 150}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
